// File: rtl/dac_pkg.sv
// Shared constants, state encoding and frame builder for the DAC update scheduler.
package dac_pkg;

    localparam int unsigned FRAME_W  = 32;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned CMD_W    = 4;

    // Field positions inside the 32-bit LTC2624-style frame
    localparam int unsigned DATA_LSB = 4;
    localparam int unsigned ADDR_LSB = DATA_LSB + SAMPLE_W;
    localparam int unsigned CMD_LSB  = ADDR_LSB + ADDR_W;

    localparam logic [CMD_W-1:0]  CMD_WR_UPD = 4'h3;
    localparam logic [ADDR_W-1:0] ADDR_ALL   = 4'hF;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE
    } state_t;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [ADDR_W-1:0]   addr,
                                                      input logic [SAMPLE_W-1:0] data);
        logic [FRAME_W-1:0] w;
        w = '0;
        w[CMD_LSB  +: CMD_W]    = CMD_WR_UPD;
        w[ADDR_LSB +: ADDR_W]   = addr;
        w[DATA_LSB +: SAMPLE_W] = data;
        return w;
    endfunction

endpackage

// File: rtl/dac_update_scheduler_if.sv
// Command-word handshake between the scheduler and the DAC serializer.
interface dac_update_scheduler_if;
    import dac_pkg::*;

    logic [FRAME_W-1:0] cmd_word;
    logic               cmd_valid;
    logic               cmd_ready;

    modport master (output cmd_word, output cmd_valid, input  cmd_ready);
    modport slave  (input  cmd_word, input  cmd_valid, output cmd_ready);

endinterface

// File: rtl/dac_pri_enc.sv
// Lowest-set-bit encoder: index of the lowest 1 in mask, plus an any-set flag.
module dac_pri_enc
    import dac_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]      mask,
    output logic [ADDR_W-1:0] idx,
    output logic              any
);

    // Scan upward and latch the first set bit found
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (mask[i] && !any) begin
                idx = ADDR_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_update_scheduler.sv
// Sample-rate sequencer: snapshots enabled voice channels on each tick and
// issues one DAC write-and-update frame per channel, after a reset-time zeroing.
module dac_update_scheduler
    import dac_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned OVR_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_en,
    dac_update_scheduler_if.master   cmd,
    output logic                     busy,
    output logic                     overrun,
    output logic [OVR_W-1:0]         overrun_cnt
);

    localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [FRAME_W-1:0] INIT_WORD = {8'h00, CMD_WR_UPD, ADDR_ALL, 12'h000, 4'h0};

    logic [CNT_W-1:0]         div_cnt;
    logic                     tick;
    state_t                   state, state_n;
    logic                     valid_q, valid_n;
    logic [NUM_CH-1:0]        pending, pending_n;
    logic [NUM_CH*DATA_W-1:0] shadow, shadow_n;
    logic                     overrun_n;
    logic [OVR_W-1:0]         ovr_cnt_n;
    logic                     busy_n;
    logic [ADDR_W-1:0]        enc_idx;
    logic                     enc_any;
    logic [DATA_W-1:0]        sel_data;
    logic [NUM_CH-1:0]        rem;
    logic                     transfer;
    logic                     last_xfer;
    logic [FRAME_W-1:0]       word_c;

    assign tick      = (div_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign transfer  = valid_q & cmd.cmd_ready;
    assign rem       = pending & ~(NUM_CH'(1) << enc_idx);
    assign last_xfer = transfer && (rem == '0);

    dac_pri_enc #(.N(NUM_CH)) u_pri_enc (
        .mask (pending),
        .idx  (enc_idx),
        .any  (enc_any)
    );

    // Free-running sample divider, independent of the FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // Select the shadowed sample of the channel currently being issued
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (enc_idx == ADDR_W'(i)) sel_data = shadow[i*DATA_W +: DATA_W];
        end
    end

    // Frame is derived from held state so it cannot change until the transfer
    always_comb begin
        word_c = '0;
        if (valid_q) begin
            if (state == ST_INIT) word_c = INIT_WORD;
            else if (enc_any)     word_c = make_frame(enc_idx, sel_data);
        end
    end

    // Next-state, snapshot, pending-mask and overrun logic
    always_comb begin
        state_n   = state;
        valid_n   = valid_q;
        pending_n = pending;
        shadow_n  = shadow;
        overrun_n = 1'b0;
        ovr_cnt_n = overrun_cnt;
        case (state)
            ST_INIT: begin
                valid_n = 1'b1;
                if (transfer) begin
                    valid_n = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (tick) begin
                    shadow_n  = ch_data;
                    pending_n = ch_en;
                    if (ch_en != '0) begin
                        state_n = ST_ISSUE;
                        valid_n = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (transfer) pending_n = rem;
                // A tick landing on the final transfer starts the next frame back-to-back
                if (last_xfer) begin
                    if (tick) begin
                        shadow_n  = ch_data;
                        pending_n = ch_en;
                    end
                    if (!tick || ch_en == '0) begin
                        state_n = ST_IDLE;
                        valid_n = 1'b0;
                    end
                end else if (tick) begin
                    overrun_n = 1'b1;
                    if (overrun_cnt != '1) ovr_cnt_n = overrun_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_INIT;
                valid_n = 1'b0;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // State and registered outputs; async reset clears everything and re-arms INIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_INIT;
            valid_q     <= 1'b0;
            pending     <= '0;
            shadow      <= '0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            valid_q     <= valid_n;
            pending     <= pending_n;
            shadow      <= shadow_n;
            overrun     <= overrun_n;
            overrun_cnt <= ovr_cnt_n;
            busy        <= busy_n;
        end
    end

    assign cmd.cmd_valid = valid_q;
    assign cmd.cmd_word  = word_c;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed self-checking bench for dac_update_scheduler (SAMPLE_DIV = 8).
module tb_dac_update_scheduler;

    localparam int DIV = 8;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] ch_data = '0;
    logic [3:0]  ch_en   = '0;
    logic        busy;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int edges;
    int exp_cnt;

    dac_update_scheduler_if bus();

    dac_update_scheduler #(
        .NUM_CH     (4),
        .DATA_W     (12),
        .SAMPLE_DIV (DIV),
        .OVR_W      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_data     (ch_data),
        .ch_en       (ch_en),
        .cmd         (bus.master),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the divider ticks in cycles where this is 7 mod 8
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the negedge of the next tick cycle (bounded)
    task automatic wait_tick();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((edges % DIV) != DIV - 1 && k < 3 * DIV);
        if ((edges % DIV) != DIV - 1) check("tick_timeout", 32'(edges % DIV), 32'(DIV - 1));
    endtask

    initial begin
        bus.cmd_ready = 1'b1;

        // 1: reset values, INIT zero word, then idle
        @(negedge clk);
        check("rst_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_word",  bus.cmd_word,       32'h0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_cnt",   32'(overrun_cnt),   32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("init_valid", 32'(bus.cmd_valid), 32'd1);
        check("init_word",  bus.cmd_word,       32'h003F0000);
        check("init_busy",  32'(busy),          32'd1);
        @(negedge clk);
        check("init_done_valid", 32'(bus.cmd_valid), 32'd0);
        check("init_done_busy",  32'(busy),          32'd0);

        // 2: channels 0 and 2, ready high -> two words back-to-back
        wait_tick();
        ch_data[0*12 +: 12] = 12'hABC;
        ch_data[2*12 +: 12] = 12'h123;
        ch_en = 4'b0101;
        @(negedge clk);
        check("f2_v0", 32'(bus.cmd_valid), 32'd1);
        check("f2_w0", bus.cmd_word,       32'h0030ABC0);
        @(negedge clk);
        check("f2_v1", 32'(bus.cmd_valid), 32'd1);
        check("f2_w1", bus.cmd_word,       32'h00321230);
        ch_en = 4'b0000;
        @(negedge clk);
        check("f2_end_valid", 32'(bus.cmd_valid), 32'd0);
        check("f2_end_busy",  32'(busy),          32'd0);

        // 3: backpressure holds the word; later input changes ignored
        wait_tick();
        ch_en = 4'b0101;
        bus.cmd_ready = 1'b0;
        @(negedge clk);
        check("f3_w0", bus.cmd_word, 32'h0030ABC0);
        ch_data = '1;
        ch_en   = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("f3_hold_valid", 32'(bus.cmd_valid), 32'd1);
            check("f3_hold_word",  bus.cmd_word,       32'h0030ABC0);
        end
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        check("f3_w1", bus.cmd_word, 32'h00321230);
        @(negedge clk);
        check("f3_end_valid", 32'(bus.cmd_valid), 32'd0);
        check("f3_ovr_cnt",   32'(overrun_cnt),   32'd1);

        // 5: tick coincides with the final transfer -> new frame, no overrun
        ch_data = '0;
        wait_tick();
        ch_data[0*12 +: 12] = 12'h111;
        ch_en = 4'b0001;
        bus.cmd_ready = 1'b0;
        wait_tick();
        check("f5_hold_word", bus.cmd_word, 32'h00301110);
        bus.cmd_ready = 1'b1;
        ch_data[1*12 +: 12] = 12'h222;
        ch_en = 4'b0010;
        @(negedge clk);
        check("f5_no_ovr",  32'(overrun),         32'd0);
        check("f5_valid",   32'(bus.cmd_valid),   32'd1);
        check("f5_word",    bus.cmd_word,         32'h00312220);
        check("f5_ovr_cnt", 32'(overrun_cnt),     32'd1);
        ch_en = 4'b0000;
        @(negedge clk);
        check("f5_end_valid", 32'(bus.cmd_valid), 32'd0);

        // 4: stalled serializer -> overrun pulse every tick, counter saturates
        wait_tick();
        ch_data = 48'h444_333_222_555;
        ch_en = 4'hF;
        bus.cmd_ready = 1'b0;
        exp_cnt = 1;
        for (int i = 0; i < 260; i++) begin
            wait_tick();
            @(negedge clk);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            check("ovr_pulse", 32'(overrun),     32'd1);
            check("ovr_cnt",   32'(overrun_cnt), 32'(exp_cnt));
        end
        @(negedge clk);
        check("ovr_pulse_end", 32'(overrun),     32'd0);
        check("ovr_sat",       32'(overrun_cnt), 32'h0000_00FF);
        check("ovr_word_held", bus.cmd_word,     32'h00305550);

        // 6: reset mid-ISSUE drops valid at once; INIT word reissued after release
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.cmd_valid), 32'd0);
        check("midrst_busy",  32'(busy),          32'd0);
        check("midrst_cnt",   32'(overrun_cnt),   32'd0);
        ch_en = 4'b0000;
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reinit_valid", 32'(bus.cmd_valid), 32'd1);
        check("reinit_word",  bus.cmd_word,       32'h003F0000);
        @(negedge clk);
        check("reinit_done", 32'(bus.cmd_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
